// File: rtl/seq_booth_mult.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per transaction; one Booth digit per clock.
// Latency WIDTH/2+1 cycles from accept to out_valid; result holds stable while out_ready is low.
module seq_booth_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int ITER = WIDTH / 2 + 1;
  // Two guard bits above the 2*WIDTH+2 minimum keep -2*mcand exact for every operand.
  localparam int ACCW = 2 * WIDTH + 4;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [ACCW-1:0]   mcand;
  logic [ACCW-1:0]   acc;
  logic [ACCW-1:0]   pp;
  logic [ACCW-1:0]   acc_nxt;
  logic [WIDTH+2:0]  mplier;
  logic [CW-1:0]     cnt;
  logic              last;
  logic              accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Booth digit from the lowest 3 bits of the (shifting) multiplier window.
  always_comb begin
    pp = '0;
    case (mplier[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
    acc_nxt = acc + pp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p      <= '0;
    end else begin
      if (accept) begin
        mcand  <= {{(ACCW-WIDTH){is_signed & a[WIDTH-1]}}, a};
        mplier <= {{2{is_signed & b[WIDTH-1]}}, b, 1'b0};
        acc    <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 2;
        mplier <= {{2{mplier[WIDTH+2]}}, mplier[WIDTH+2:2]};
        cnt    <= cnt + 1'b1;
        if (last) p <= acc_nxt[2*WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Bench for seq_booth_mult: directed plan vectors plus randomised runs at WIDTH=8 and WIDTH=16.
module tb_seq_booth_mult;

  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  logic        iv8 = 0, ir8, s8 = 0, ov8, or8 = 1;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;

  logic        iv16 = 0, ir16, s16 = 0, ov16, or16 = 1;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;

  int checks = 0;
  int errors = 0;

  seq_booth_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .p(p8)
  );

  seq_booth_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .p(p16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Product from plain integer arithmetic on the operands' interpreted values.
  function automatic logic [63:0] refmul(input logic [31:0] x, input logic [31:0] y,
                                         input logic s, input int w);
    longint vx, vy;
    logic [63:0] mask;
    vx = longint'({32'b0, x});
    vy = longint'({32'b0, y});
    if (s && x[w-1]) vx = vx - (longint'(1) << w);
    if (s && y[w-1]) vy = vy - (longint'(1) << w);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(vx * vy) & mask;
  endfunction

  task automatic start8(input logic [7:0] ia, input logic [7:0] ib, input logic s);
    int n = 0;
    while (!ir8 && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready8", 64'(ir8), 64'd1);
    a8 = ia; b8 = ib; s8 = s; iv8 = 1;
    @(posedge clk); #1;
    iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s;
  endtask

  task automatic wait8(output int lat);
    lat = 0;
    while (!ov8 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("out_valid8_timeout", 64'(ov8), 64'd1);
  endtask

  task automatic do8(input logic [7:0] ia, input logic [7:0] ib, input logic s,
                     output logic [15:0] pr, output int lat);
    start8(ia, ib, s);
    wait8(lat);
    pr = p8;
    @(posedge clk); #1;
    check("post_hs_ov8", 64'(ov8), 64'd0);
    check("post_hs_ir8", 64'(ir8), 64'd1);
  endtask

  task automatic do16(input logic [15:0] ia, input logic [15:0] ib, input logic s,
                      output logic [31:0] pr, output int lat);
    int n = 0;
    while (!ir16 && n < 50) begin @(posedge clk); #1; n++; end
    check("in_ready16", 64'(ir16), 64'd1);
    a16 = ia; b16 = ib; s16 = s; iv16 = 1;
    @(posedge clk); #1;
    iv16 = 0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = ~s;
    lat = 0;
    while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("out_valid16_timeout", 64'(ov16), 64'd1);
    pr = p16;
    @(posedge clk); #1;
  endtask

  int          da[16] = '{-128, -128, -128, -128, -128, 15, 100, -100, -70, 52, 0, 255, 255, 128, 7, -1};
  int          db[16] = '{-66, -114, -50, -121, -128, 7, 83, 83, -105, -41, -26, 255, 255, 2, 9, 1};
  logic        ds[16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1};
  int          de[16] = '{8448, 14592, 6400, 15488, 16384, 105, 8300, -8300, 7350, -2132, 0,
                          'hFE01, 1, 256, 63, -1};

  initial begin
    logic [15:0] r8, hold_p;
    logic [31:0] r16;
    logic [15:0] e16;
    logic [7:0]  ta, tb;
    logic [15:0] ua, ub;
    logic        ts;
    int          lat;
    logic        seen;

    #2;
    check("rst_ov8", 64'(ov8), 64'd0);
    check("rst_p8", 64'(p8), 64'd0);
    check("rst_ov16", 64'(ov16), 64'd0);
    check("rst_p16", 64'(p16), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    #1;
    check("rst_ir8", 64'(ir8), 64'd1);
    check("rst_ir16", 64'(ir16), 64'd1);

    for (int i = 0; i < 16; i++) begin
      ta = 8'(da[i]); tb = 8'(db[i]); e16 = 16'(de[i]);
      do8(ta, tb, ds[i], r8, lat);
      check($sformatf("dir8_%0d", i), 64'(r8), 64'(e16));
      check($sformatf("lat8_%0d", i), 64'(lat), 64'd5);
    end

    // Backpressure: result and flags must hold while the consumer stalls.
    or8 = 0;
    start8(8'd52, 8'hD7, 1'b1);
    wait8(lat);
    hold_p = p8;
    check("bp_p", 64'(hold_p), 64'(16'hF7AC));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_ov", 64'(ov8), 64'd1);
      check("bp_hold", 64'(p8), 64'(hold_p));
      check("bp_ir", 64'(ir8), 64'd0);
    end
    or8 = 1;
    @(posedge clk); #1;
    check("bp_release_ov", 64'(ov8), 64'd0);
    check("bp_release_ir", 64'(ir8), 64'd1);
    check("bp_p_keep", 64'(p8), 64'(hold_p));

    // Reset two cycles into a calculation.
    start8(8'd100, 8'd83, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("midrst_ov", 64'(ov8), 64'd0);
    check("midrst_p", 64'(p8), 64'd0);
    check("midrst_ir", 64'(ir8), 64'd1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov8) seen = 1;
    end
    check("midrst_no_ov", 64'(seen), 64'd0);
    do8(8'd3, 8'd4, 1'b1, r8, lat);
    check("midrst_3x4", 64'(r8), 64'd12);

    for (int i = 0; i < 300; i++) begin
      ta = 8'($urandom); tb = 8'($urandom); ts = 1'($urandom);
      do8(ta, tb, ts, r8, lat);
      check("rand8", 64'(r8), refmul(32'(ta), 32'(tb), ts, 8));
      check("rand8_lat", 64'(lat), 64'd5);
    end

    do16(16'h8000, 16'h8000, 1'b1, r16, lat);
    check("dir16_minmin", 64'(r16), 64'(32'h40000000));
    check("dir16_lat", 64'(lat), 64'd9);
    for (int i = 0; i < 1000; i++) begin
      ua = 16'($urandom); ub = 16'($urandom);
      if (i % 50 == 0) ua = 16'h8000;
      do16(ua, ub, 1'b1, r16, lat);
      check("rand16", 64'(r16), refmul(32'(ua), 32'(ub), 1'b1, 16));
      check("rand16_lat", 64'(lat), 64'd9);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_booth_mult.md
Name: seq_booth_mult

Overview:
Sequential radix-4 Booth multiplier, parametrised in operand width, with valid/ready handshakes on both the input and output sides. It is the successor to the combinational 8x8 signed Booth multiplier. It retires one Booth group per clock and selects signed or unsigned operation per transaction. It is exact for every operand pair, including the most-negative multiplicand, which the previous generation mishandled. It sits between operand-producing datapath logic and any consumer that can apply backpressure.

Parameters:
WIDTH, 8, operand width in bits. Must be even and at least 4. The product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock, the only clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b and is_signed are valid this cycle
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = operands are two's complement; 0 = operands are unsigned
out_valid  output  1  p holds a finished product
out_ready  input  1  consumer accepts p
p  output  2*WIDTH  product: signed if is_signed, otherwise unsigned

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, out_valid=0, p=0, all internal registers cleared.
  - in_ready=1 once rst_n deasserts.
- Reset mid-operation: the transaction in progress is abandoned and no out_valid pulse is produced.
- State machine:
  - IDLE -> CALC on in_valid && in_ready.
  - CALC -> DONE after ITER = WIDTH/2+1 iteration edges.
  - DONE -> IDLE on out_valid && out_ready.
- in_ready is combinational: it equals (state==IDLE). in_valid is ignored in CALC and DONE.
- Accept edge: capture operands and extend both to WIDTH+2 bits.
  - Sign-extend when is_signed=1; zero-extend when is_signed=0.
  - Clear the accumulator and the iteration counter.
- Multiplier encoding: the extended multiplier with an implicit 0 appended below bit 0 gives ITER overlapping 3-bit groups.
  - Each group maps to a digit: 000/111=0, 001/010=+1, 011=+2, 100=-2, 101/110=-1.
- Per CALC edge: the accumulator adds digit*multiplicand shifted left by 2*k.
  - Arithmetic is at least 2*WIDTH+2 bits wide, so -2*(-2^(WIDTH-1)) = 2^WIDTH is representable.
  - The previous generation's error at a = -2^(WIDTH-1) must not occur.
- DONE:
  - On the last CALC edge, p is loaded with accumulator[2*WIDTH-1:0] and out_valid=1.
  - Latency is ITER cycles from the accept edge to out_valid high (5 for WIDTH=8).
- Backpressure: while out_valid=1 && out_ready=0, p and out_valid hold stable indefinitely.
- Handshake completion:
  - On out_valid && out_ready, out_valid drops on that edge and state returns to IDLE.
  - p keeps its last value until the next DONE.
  - A new operand cannot be accepted until the cycle after the handshake.
- Throughput: one result per ITER+2 cycles with out_ready held high.
- Overflow: none. The full product always fits in 2*WIDTH bits (unsigned maximum (2^W-1)^2; signed maximum 2^(2W-2)).
- is_signed is sampled only on the accept edge. Changes to it during CALC have no effect.

Test Plan:
- Most-negative multiplicand, WIDTH=8, is_signed=1, out_ready=1:
  - a=-128, b=-66 -> p=8448
  - a=-128, b=-114 -> p=14592
  - a=-128, b=-50 -> p=6400
  - a=-128, b=-121 -> p=15488
  - a=-128, b=-128 -> p=16384
  - each out_valid arrives exactly 5 cycles after acceptance.
- Signed regression:
  - 15*7 -> 105
  - 100*83 -> 8300
  - -100*83 -> -8300
  - -70*-105 -> 7350
  - 52*-41 -> -2132
  - 0*-26 -> 0
- Unsigned mode:
  - a=8'hFF, b=8'hFF, is_signed=0 -> p=16'hFE01
  - the same bits with is_signed=1 -> p=16'h0001
  - a=8'h80, b=8'h02, is_signed=0 -> p=256.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - p and out_valid stay stable and in_ready stays 0.
  - Assert out_ready for one cycle -> out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-CALC: pulse rst_n low 2 cycles after acceptance.
  - Outputs clear immediately (asynchronously) and out_valid never rises.
  - A following 3*4 transaction returns 12.
- WIDTH=16 instance, signed, randomised against a reference model (at least 1000 vectors):
  - directed case -32768*-32768 -> p=32'h40000000
  - latency of 9 cycles every transaction.
